// File: rtl/cmp_result_monitor.sv
// rtl/cmp_result_monitor.sv - windowed outcome statistics for the 2-bit magnitude comparator
// Counts gt/eq/lt/illegal outcomes per window and flags runs of consecutive equal results.
module cmp_result_monitor #(
  parameter int CNT_W   = 8,
  parameter int WINDOW  = 16,
  parameter int RUN_THR = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sample_en,
  input  logic             f1,
  input  logic             f2,
  input  logic             f3,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             busy,
  output logic             done,
  output logic             eq_streak
);

  localparam int RW = (RUN_THR < 1) ? 1 : $clog2(RUN_THR + 1);
  localparam logic [RW-1:0] THR = RW'(RUN_THR);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_gt;
  logic [CNT_W-1:0] r_eq;
  logic [CNT_W-1:0] r_lt;
  logic [CNT_W-1:0] r_err;
  logic [CNT_W-1:0] r_sample;
  logic [RW-1:0]    r_run;
  logic             r_busy;
  logic             r_done;
  logic             r_streak;

  logic             w_accept;
  logic             w_is_gt;
  logic             w_is_eq;
  logic             w_is_lt;
  logic             w_last;
  logic [RW-1:0]    w_run_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // start takes priority over a coincident sample strobe
  assign w_accept = (r_state == S_RUN) && sample_en && !start;
  assign w_is_gt  = ({f1, f2, f3} == 3'b100);
  assign w_is_eq  = ({f1, f2, f3} == 3'b010);
  assign w_is_lt  = ({f1, f2, f3} == 3'b001);

  always_comb begin
    w_last = 1'b0;
    if (WINDOW != 0)
      w_last = ((32'(r_sample) + 32'd1) == 32'(WINDOW));
  end

  always_comb begin
    w_run_nxt = '0;
    if (w_is_eq)
      w_run_nxt = (r_run == THR) ? r_run : r_run + RW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_gt     <= '0;
      r_eq     <= '0;
      r_lt     <= '0;
      r_err    <= '0;
      r_sample <= '0;
      r_run    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_streak <= 1'b0;
    end else if (start) begin
      r_state  <= S_RUN;
      r_gt     <= '0;
      r_eq     <= '0;
      r_lt     <= '0;
      r_err    <= '0;
      r_sample <= '0;
      r_run    <= '0;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
      r_streak <= 1'b0;
    end else if (w_accept) begin
      if (w_is_gt)
        r_gt <= sat_inc(r_gt);
      else if (w_is_eq)
        r_eq <= sat_inc(r_eq);
      else if (w_is_lt)
        r_lt <= sat_inc(r_lt);
      else
        r_err <= sat_inc(r_err);
      r_sample <= sat_inc(r_sample);
      r_run    <= w_run_nxt;
      if (w_run_nxt == THR)
        r_streak <= 1'b1;
      if (w_last) begin
        r_state <= S_DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

  assign gt_cnt     = r_gt;
  assign eq_cnt     = r_eq;
  assign lt_cnt     = r_lt;
  assign err_cnt    = r_err;
  assign sample_cnt = r_sample;
  assign busy       = r_busy;
  assign done       = r_done;
  assign eq_streak  = r_streak;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// tb/tb_cmp_result_monitor.sv - bench for cmp_result_monitor
// Two instances share stimulus: (8-bit, window 16, run 4) and (4-bit, free-running, run 1).
module tb_cmp_result_monitor;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic sample_en;
  logic f1, f2, f3;

  logic [7:0] gt0, eq0, lt0, er0, sc0;
  logic [3:0] gt1, eq1, lt1, er1, sc1;
  logic       busy0, done0, stk0, busy1, done1, stk1;

  int checks = 0;
  int errors = 0;

  // reference model: state 0 idle, 1 run, 2 done; class 0 gt, 1 eq, 2 lt, 3 illegal
  int p_cw  [2] = '{8, 4};
  int p_win [2] = '{16, 0};
  int p_thr [2] = '{4, 1};
  int m_state [2];
  int m_cnt   [2][4];
  int m_smp   [2];
  int m_run   [2];
  int m_stk   [2];

  always #5 clk = ~clk;

  cmp_result_monitor #(.CNT_W(8), .WINDOW(16), .RUN_THR(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_en(sample_en),
    .f1(f1), .f2(f2), .f3(f3),
    .gt_cnt(gt0), .eq_cnt(eq0), .lt_cnt(lt0), .err_cnt(er0), .sample_cnt(sc0),
    .busy(busy0), .done(done0), .eq_streak(stk0)
  );

  cmp_result_monitor #(.CNT_W(4), .WINDOW(0), .RUN_THR(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_en(sample_en),
    .f1(f1), .f2(f2), .f3(f3),
    .gt_cnt(gt1), .eq_cnt(eq1), .lt_cnt(lt1), .err_cnt(er1), .sample_cnt(sc1),
    .busy(busy1), .done(done1), .eq_streak(stk1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0;
      m_smp[i]   = 0;
      m_run[i]   = 0;
      m_stk[i]   = 0;
      for (int c = 0; c < 4; c++) m_cnt[i][c] = 0;
    end
  endtask

  task automatic model_edge(input bit st, input bit se, input bit [2:0] fv);
    int mx;
    int cls;
    for (int i = 0; i < 2; i++) begin
      mx = (1 << p_cw[i]) - 1;
      if (st) begin
        m_state[i] = 1;
        m_smp[i]   = 0;
        m_run[i]   = 0;
        m_stk[i]   = 0;
        for (int c = 0; c < 4; c++) m_cnt[i][c] = 0;
      end else if (m_state[i] == 1 && se) begin
        cls = (fv == 3'b100) ? 0 : (fv == 3'b010) ? 1 : (fv == 3'b001) ? 2 : 3;
        if (m_cnt[i][cls] < mx) m_cnt[i][cls]++;
        if (m_smp[i] < mx) m_smp[i]++;
        m_run[i] = (cls == 1) ? m_run[i] + 1 : 0;
        if (m_run[i] >= p_thr[i]) m_stk[i] = 1;
        if (p_win[i] != 0 && m_smp[i] == p_win[i]) m_state[i] = 2;
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_d%0d_gt", ph, i),  (i == 0) ? 32'(gt0) : 32'(gt1), m_cnt[i][0]);
      chk($sformatf("%s_d%0d_eq", ph, i),  (i == 0) ? 32'(eq0) : 32'(eq1), m_cnt[i][1]);
      chk($sformatf("%s_d%0d_lt", ph, i),  (i == 0) ? 32'(lt0) : 32'(lt1), m_cnt[i][2]);
      chk($sformatf("%s_d%0d_err", ph, i), (i == 0) ? 32'(er0) : 32'(er1), m_cnt[i][3]);
      chk($sformatf("%s_d%0d_smp", ph, i), (i == 0) ? 32'(sc0) : 32'(sc1), m_smp[i]);
      chk($sformatf("%s_d%0d_busy", ph, i), 32'((i == 0) ? busy0 : busy1), 32'(m_state[i] == 1));
      chk($sformatf("%s_d%0d_done", ph, i), 32'((i == 0) ? done0 : done1), 32'(m_state[i] == 2));
      chk($sformatf("%s_d%0d_stk", ph, i),  32'((i == 0) ? stk0 : stk1), m_stk[i]);
    end
  endtask

  task automatic step(input string ph, input bit st, input bit se, input bit [2:0] fv);
    start = st;
    sample_en = se;
    {f1, f2, f3} = fv;
    @(posedge clk);
    model_edge(st, se, fv);
    #1;
    check_all(ph);
  endtask

  task automatic gap(input string ph, input int n);
    for (int k = 0; k < n; k++) step(ph, 1'b0, 1'b0, 3'($urandom_range(0, 7)));
  endtask

  initial begin
    bit [1:0] a, b;
    rst_n = 1'b0;
    start = 1'b0;
    sample_en = 1'b0;
    {f1, f2, f3} = 3'b000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // idle: strobes without start are ignored
    for (int k = 0; k < 6; k++) step("idle", 1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));

    // full sweep of all A/B combinations
    step("sw", 1'b1, 1'b0, 3'b000);
    for (int v = 0; v < 16; v++) begin
      a = 2'(v >> 2);
      b = 2'(v);
      step("sw", 1'b0, 1'b1, {a > b, a == b, a < b});
      gap("sw", $urandom_range(0, 1));
    end
    chk("sweep_gt", 32'(gt0), 6);
    chk("sweep_eq", 32'(eq0), 4);
    chk("sweep_lt", 32'(lt0), 6);
    chk("sweep_err", 32'(er0), 0);
    chk("sweep_smp", 32'(sc0), 16);
    chk("sweep_done", 32'(done0), 1);
    step("sw17", 1'b0, 1'b1, 3'b100);
    chk("sweep17_gt", 32'(gt0), 6);

    // illegal patterns
    step("ill", 1'b1, 1'b0, 3'b000);
    step("ill", 1'b0, 1'b1, 3'b000);
    step("ill", 1'b0, 1'b1, 3'b110);
    step("ill", 1'b0, 1'b1, 3'b111);
    step("ill", 1'b0, 1'b1, 3'b010);
    chk("ill_err", 32'(er0), 3);
    chk("ill_eq", 32'(eq0), 1);
    chk("ill_stk", 32'(stk0), 0);

    // streak detection with idle gaps inside the run
    step("stk", 1'b1, 1'b0, 3'b000);
    for (int k = 0; k < 8; k++) begin
      step("stk", 1'b0, 1'b1, (k == 3) ? 3'b100 : 3'b010);
      if (k == 6) chk("stk_before", 32'(stk0), 0);
      if (k == 7) chk("stk_after", 32'(stk0), 1);
      gap("stk", 2);
    end
    step("stk", 1'b1, 1'b0, 3'b000);
    chk("stk_cleared", 32'(stk0), 0);

    // saturation on the 4-bit free-running instance
    for (int k = 0; k < 20; k++) step("sat", 1'b0, 1'b1, 3'b100);
    chk("sat_gt", 32'(gt1), 15);
    chk("sat_smp", 32'(sc1), 15);
    chk("sat_busy", 32'(busy1), 1);
    chk("sat_done", 32'(done1), 0);

    // restart mid-window: coincident sample is dropped
    step("rs", 1'b1, 1'b0, 3'b000);
    for (int k = 0; k < 5; k++) step("rs", 1'b0, 1'b1, 3'($urandom_range(0, 7)));
    step("rs", 1'b1, 1'b1, 3'b010);
    chk("restart_smp", 32'(sc0), 0);

    // randomized traffic
    for (int k = 0; k < 300; k++)
      step("rnd", ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));

    // asynchronous reset between edges
    step("ar", 1'b1, 1'b0, 3'b000);
    for (int k = 0; k < 3; k++) step("ar", 1'b0, 1'b1, 3'b010);
    start = 1'b0;
    sample_en = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async");
    @(negedge clk);
    rst_n = 1'b1;
    step("post", 1'b0, 1'b1, 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_result_monitor.md
Name: cmp_result_monitor

Overview:
- Sequential consumer placed directly downstream of the 2-bit magnitude comparator; takes its three outcome lines (f1 = A>B, f2 = A==B, f3 = A<B).
- Over a measurement window, the block:
  - samples the outcome lines on a strobe;
  - counts each outcome class;
  - flags illegal (non-one-hot) outcomes;
  - detects runs of consecutive "equal" results.
- Used on the board and in benches as a self-checking statistics stage for the comparator.

Parameters:
- CNT_W, 8, width of each class counter and of sample_cnt.
- WINDOW, 16, number of accepted samples per window; 0 = free-running (no DONE state).
- RUN_THR, 4, consecutive accepted equal samples needed to assert eq_streak; must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  clears statistics and (re)starts a window.
- sample_en  input  1  sample strobe; f1/f2/f3 captured on the rising clk edge where sample_en=1 in RUN.
- f1  input  1  comparator A>B.
- f2  input  1  comparator A==B.
- f3  input  1  comparator A<B.
- gt_cnt  output  CNT_W  accepted samples with {f1,f2,f3}=100.
- eq_cnt  output  CNT_W  accepted samples with 010.
- lt_cnt  output  CNT_W  accepted samples with 001.
- err_cnt  output  CNT_W  accepted samples with any other pattern.
- sample_cnt  output  CNT_W  total accepted samples in the current window.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- eq_streak  output  1  sticky: a run of ≥RUN_THR equal samples occurred this window.

Behaviour:

Reset:
- rst_n=0 asynchronously forces state IDLE and clears all counters, the internal run counter, and busy/done/eq_streak.
- Applies mid-window as well; no partial results are kept.

States: IDLE, RUN, DONE.
- IDLE: counters hold. start=1 → clear all stats, next state RUN.
- RUN: busy=1. start=1 → clear all stats, stay RUN; a sample_en in that same cycle is discarded (clear wins).
  - Otherwise, on sample_en=1, decode {f1,f2,f3}:
    - 100 → gt_cnt+1
    - 010 → eq_cnt+1
    - 001 → lt_cnt+1
    - else → err_cnt+1
  - Every accepted sample also increments sample_cnt.
  - If WINDOW≠0 and the accepted sample is the WINDOW-th, next state DONE.
- DONE: done=1, all outputs frozen, sample_en ignored. start=1 → clear, next state RUN.

Latency: all counter and flag updates are registered; values are visible the cycle after the accepting edge. done rises in the cycle after the WINDOW-th sample.

Saturation: every counter (including sample_cnt) saturates at 2^CNT_W−1 and never wraps. Saturation is only reachable in free-running mode or when WINDOW > 2^CNT_W−1.

Equal-run detection:
- The internal run counter (saturating, width ≥ clog2(RUN_THR+1)) is cleared by start.
- An accepted 010 increments it; any other accepted sample, including illegal ones, clears it.
- Cycles with sample_en=0 do not break a run.
- eq_streak is set when the run counter reaches RUN_THR. It is sticky until start or reset.
- With RUN_THR=1, any accepted 010 sets eq_streak.

Other rules:
- Inputs are treated as synchronous to clk; no synchronizer is included.
- start and sample_en are level-sampled, not edge-detected.
  - Holding start high keeps the block clearing in RUN.
  - Holding start high in DONE → RUN with stats cleared, which then keep clearing while start remains high.

Test Plan:
1. Reset/idle: rst_n low for 3 cycles, then high, no start, toggle f-lines and sample_en → all counters 0, busy=0, done=0, eq_streak=0.
2. Full sweep: WINDOW=16, start, then drive the comparator outputs for A={a,b}, B={c,d} over all 16 combinations, one per sample_en pulse → gt_cnt=6, eq_cnt=4, lt_cnt=6, err_cnt=0, sample_cnt=16. done rises the cycle after the 16th sample; a 17th pulse changes nothing.
3. Illegal patterns: window of 4 samples with {f1,f2,f3} = 000, 110, 111, 010 → err_cnt=3, eq_cnt=1, run counter 1, eq_streak=0.
4. Streak, RUN_THR=4:
   - 010 ×3, then 100, then 010 ×4 with sample_en gaps of 2 idle cycles → eq_streak asserts only the cycle after the 8th sample (4th equal of the second run); gaps do not break the run.
   - A following start clears eq_streak.
5. Saturation: CNT_W=4, WINDOW=0, 20 accepted 100 samples → gt_cnt and sample_cnt stick at 15, state stays RUN, done=0.
6. Restart/reset mid-window:
   - start pulsed after 5 samples (with sample_en=1 that cycle) → all counters 0 next cycle, that sample not counted.
   - Asynchronous rst_n low between clock edges → outputs clear immediately, state IDLE.
